// File: rtl/sr_latch_ctrl_if.sv
// Requester-side handshake bundle for sr_latch_ctrl: per-requester valid/op and one-hot ready.
interface sr_latch_ctrl_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_set;
    logic [NREQ-1:0] req_ready;

    modport master (output req_valid, output req_set, input req_ready);
    modport slave  (input req_valid, input req_set, output req_ready);
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer of set/clear pulses onto a shared SR latch; S and R never overlap.
// Optional post-operation Q readback check enabled by defining SR_VERIFY_EN.
module sr_latch_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_latch_ctrl_if.slave req,
    input  logic           q_in,
    output logic           S,
    output logic           R,
    output logic           busy,
    output logic           done,
    output logic [IDW-1:0] done_id,
    output logic           err
);

    localparam int unsigned CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StCheck} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            op_q, op_d;
    logic            s_q, s_d, r_q, r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic            err_q, err_d;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] ready;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned k);
        return IDW'((32'(base) + k) % NREQ);
    endfunction

    // First valid requester at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_found && req.req_valid[wrap_add(rr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_q, k);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == StIdle && rst_n && grant_found) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign req.req_ready = ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        id_d      = id_q;
        op_d      = op_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d = StPulse;
                    id_d    = grant_idx;
                    op_d    = req.req_set[grant_idx];
                    rr_d    = wrap_add(grant_idx, 1);
                    cnt_d   = '0;
                    s_d     = req.req_set[grant_idx];
                    r_d     = ~req.req_set[grant_idx];
                end
            end
            StPulse: begin
                if (cnt_q == CW'(PULSE_W - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    s_d   = op_q;
                    r_d   = ~op_q;
                end
            end
            StGap: begin
                if (cnt_q == CW'(GAP_W - 1)) begin
                    cnt_d = '0;
`ifdef SR_VERIFY_EN
                    state_d = StCheck;
`else
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    done_id_d = id_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SR_VERIFY_EN
            StCheck: begin
                state_d   = StIdle;
                done_d    = 1'b1;
                done_id_d = id_q;
                if (q_in != op_q) begin
                    err_d = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

`ifndef SR_VERIFY_EN
    logic unused_q_in;
    assign unused_q_in = q_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rr_q      <= '0;
            id_q      <= '0;
            op_q      <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            s_q       <= s_d;
            r_q       <= r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    assign S       = s_q;
    assign R       = r_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;

endmodule
